con_ff_unit: RTL and testbench

Parametrised successor to the conditional-branch flip-flop in the MiniSRC datapath. It evaluates a branch condition on the Bus operand under control of the IR condition field and registers the decision for the control unit. It extends the original with:
- configurable operand width
- a 3-bit condition code with 8 modes
- an optional input pipeline stage
- a sticky result with a valid/ack handshake
- saturating evaluated/taken statistics counters

---
 rtl/con_ff_unit.sv | 173 +++++++++++++++++
 tb/tb_con_ff_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/con_ff_unit.sv
// con_ff_unit: conditional-branch flip-flop for the MiniSRC control path.
// Evaluates a condition code against the Bus operand, registers the decision
// behind a valid/ack output stage and keeps saturating evaluation statistics.
module con_ff_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE       = 0,
    parameter int HOLD       = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Clear_n,
    input  logic                  CONin,
    input  logic [2:0]            IR,
    input  logic [DATA_WIDTH-1:0] Bus,
    input  logic                  BranchAck,
    input  logic                  CntClr,
    output logic                  BranchOut,
    output logic                  BranchValid,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  EvalCount,
    output logic [CNT_WIDTH-1:0]  TakenCount
);

    typedef enum logic [2:0] {
        C_BRZR   = 3'b000,
        C_BRNZ   = 3'b001,
        C_BRPL   = 3'b010,
        C_BRMI   = 3'b011,
        C_ALWAYS = 3'b100,
        C_NEVER  = 3'b101,
        C_BRGT   = 3'b110,
        C_BRLE   = 3'b111
    } cond_t;

    typedef enum logic {
        IDLE,
        RESULT
    } state_t;

    // Evaluation source: either the live inputs or the registered stage
    logic                  ev_vld;
    logic [2:0]            ev_ir;
    logic [DATA_WIDTH-1:0] ev_bus;
    logic                  ev_z;
    logic                  ev_n;
    logic                  ev_dec;

    state_t                state_q, state_d;
    logic                  out_q, out_d;
    logic [CNT_WIDTH-1:0]  eval_q, eval_d;
    logic [CNT_WIDTH-1:0]  taken_q, taken_d;

    if (PIPE != 0) begin : g_pipe
        logic                  stg_vld_q;
        logic [2:0]            stg_ir_q;
        logic [DATA_WIDTH-1:0] stg_bus_q;

        // Input stage: capture the condition and operand of each request
        always_ff @(posedge Clock or negedge Clear_n) begin
            if (!Clear_n) begin
                stg_vld_q <= 1'b0;
                stg_ir_q  <= '0;
                stg_bus_q <= '0;
            end else begin
                stg_vld_q <= CONin;
                if (CONin) begin
                    stg_ir_q  <= IR;
                    stg_bus_q <= Bus;
                end
            end
        end

        assign ev_vld = stg_vld_q;
        assign ev_ir  = stg_ir_q;
        assign ev_bus = stg_bus_q;
        assign Busy   = stg_vld_q;
    end else begin : g_direct
        assign ev_vld = CONin;
        assign ev_ir  = IR;
        assign ev_bus = Bus;
        assign Busy   = 1'b0;
    end

    // Branch decision from the zero/negative flags of the operand
    always_comb begin
        ev_z   = (ev_bus == '0);
        ev_n   = ev_bus[DATA_WIDTH-1];
        ev_dec = 1'b0;
        unique case (cond_t'(ev_ir))
            C_BRZR:   ev_dec = ev_z;
            C_BRNZ:   ev_dec = !ev_z;
            C_BRPL:   ev_dec = !ev_n;
            C_BRMI:   ev_dec = ev_n;
            C_ALWAYS: ev_dec = 1'b1;
            C_NEVER:  ev_dec = 1'b0;
            C_BRGT:   ev_dec = !ev_n && !ev_z;
            C_BRLE:   ev_dec = ev_n || ev_z;
            default:  ev_dec = 1'b0;
        endcase
    end

    // Output stage next state: a completing result always wins over an ack
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                out_d = 1'b0;
                if (ev_vld) begin
                    state_d = RESULT;
                    out_d   = ev_dec;
                end
            end
            RESULT: begin
                if (ev_vld) begin
                    out_d = ev_dec;
                end else if ((HOLD == 0) || BranchAck) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
            end
        endcase
    end

    // Output stage state register
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Statistics next state: clear beats increment, increments saturate
    always_comb begin
        eval_d  = eval_q;
        taken_d = taken_q;
        if (CntClr) begin
            eval_d  = '0;
            taken_d = '0;
        end else if (ev_vld) begin
            if (eval_q != '1) begin
                eval_d = eval_q + CNT_WIDTH'(1);
            end
            if (ev_dec && (taken_q != '1)) begin
                taken_d = taken_q + CNT_WIDTH'(1);
            end
        end
    end

    // Statistics counter registers
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            eval_q  <= '0;
            taken_q <= '0;
        end else begin
            eval_q  <= eval_d;
            taken_q <= taken_d;
        end
    end

    assign BranchOut   = out_q;
    assign BranchValid = (state_q == RESULT);
    assign EvalCount   = eval_q;
    assign TakenCount  = taken_q;

endmodule

// File: tb/tb_con_ff_unit.sv
// Scoreboard bench for con_ff_unit: three configurations share one stimulus
// stream; expected decisions are queued at issue time and checked by a monitor.
module tb_con_ff_unit;

    logic        Clock = 1'b0;
    logic        Clear_n;
    logic        CONin;
    logic [2:0]  IR;
    logic [31:0] Bus;
    logic        BranchAck;
    logic        CntClr;

    logic        bo0, bv0, bs0, bo1, bv1, bs1, bo2, bv2, bs2;
    logic [15:0] ec0, tc0;
    logic [2:0]  ec1, tc1;
    logic [1:0]  ec2, tc2;

    always #5 Clock = ~Clock;

    con_ff_unit #(.DATA_WIDTH(32), .PIPE(0), .HOLD(0), .CNT_WIDTH(16)) dut0 (
        .Clock(Clock), .Clear_n(Clear_n), .CONin(CONin), .IR(IR), .Bus(Bus),
        .BranchAck(BranchAck), .CntClr(CntClr), .BranchOut(bo0),
        .BranchValid(bv0), .Busy(bs0), .EvalCount(ec0), .TakenCount(tc0));

    con_ff_unit #(.DATA_WIDTH(8), .PIPE(1), .HOLD(1), .CNT_WIDTH(3)) dut1 (
        .Clock(Clock), .Clear_n(Clear_n), .CONin(CONin), .IR(IR), .Bus(Bus[7:0]),
        .BranchAck(BranchAck), .CntClr(CntClr), .BranchOut(bo1),
        .BranchValid(bv1), .Busy(bs1), .EvalCount(ec1), .TakenCount(tc1));

    con_ff_unit #(.DATA_WIDTH(16), .PIPE(1), .HOLD(0), .CNT_WIDTH(2)) dut2 (
        .Clock(Clock), .Clear_n(Clear_n), .CONin(CONin), .IR(IR), .Bus(Bus[15:0]),
        .BranchAck(BranchAck), .CntClr(CntClr), .BranchOut(bo2),
        .BranchValid(bv2), .Busy(bs2), .EvalCount(ec2), .TakenCount(tc2));

    // Per-instance views of outputs and configuration
    logic bo_a [3];
    logic bv_a [3];
    logic bs_a [3];
    int   ec_a [3];
    int   tc_a [3];

    assign bo_a[0] = bo0;
    assign bo_a[1] = bo1;
    assign bo_a[2] = bo2;
    assign bv_a[0] = bv0;
    assign bv_a[1] = bv1;
    assign bv_a[2] = bv2;
    assign bs_a[0] = bs0;
    assign bs_a[1] = bs1;
    assign bs_a[2] = bs2;
    assign ec_a[0] = int'(ec0);
    assign ec_a[1] = int'(ec1);
    assign ec_a[2] = int'(ec2);
    assign tc_a[0] = int'(tc0);
    assign tc_a[1] = int'(tc1);
    assign tc_a[2] = int'(tc2);

    function automatic int dw(int i);
        return (i == 0) ? 32 : (i == 1) ? 8 : 16;
    endfunction
    function automatic int pp(int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int hd(int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int cmax(int i);
        return (i == 0) ? 65535 : (i == 1) ? 7 : 3;
    endfunction

    // Reference decision: condition table applied to the low w bits of b
    function automatic bit ref_dec(bit [2:0] c, logic [31:0] b, int w);
        logic [31:0] m;
        bit z, n;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        z = ((b & m) == 32'd0);
        n = b[w-1];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return !n;
            3'd3: return n;
            3'd4: return 1'b1;
            3'd5: return 1'b0;
            3'd6: return !n && !z;
            default: return n || z;
        endcase
    endfunction

    typedef struct {
        int due;
        bit dec;
    } ent_t;

    ent_t sbq [3][$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ecount = 0;

    always @(posedge Clock) ecount <= ecount + 1;

    task automatic chk(string nm, int i, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @edge %0d: got %0d expected %0d", nm, i, ecount, act, exp);
        end
    endtask

    // Monitor with output-stage reference model
    bit mv  [3] = '{default: 0};
    bit mo  [3] = '{default: 0};
    int mec [3] = '{default: 0};
    int mtc [3] = '{default: 0};
    bit ack_s = 1'b0;
    bit clr_s = 1'b0;

    initial begin
        forever begin
            @(negedge Clock);
            for (int i = 0; i < 3; i++) begin
                bit done, d, busy_e;
                if (!Clear_n) begin
                    mv[i] = 0; mo[i] = 0; mec[i] = 0; mtc[i] = 0;
                    busy_e = 0;
                end else begin
                    done = (sbq[i].size() > 0) && (sbq[i][0].due == ecount);
                    d = 0;
                    if (done) begin
                        d = sbq[i][0].dec;
                        void'(sbq[i].pop_front());
                        mv[i] = 1;
                        mo[i] = d;
                    end else if (mv[i] && (hd(i) == 0 || ack_s)) begin
                        mv[i] = 0;
                        mo[i] = 0;
                    end
                    if (clr_s) begin
                        mec[i] = 0;
                        mtc[i] = 0;
                    end else if (done) begin
                        if (mec[i] < cmax(i)) mec[i]++;
                        if (d && mtc[i] < cmax(i)) mtc[i]++;
                    end
                    busy_e = (pp(i) != 0) && (sbq[i].size() > 0) && (sbq[i][0].due == ecount + 1);
                end
                chk("BranchOut", i, int'(bo_a[i]), int'(mo[i]));
                chk("BranchValid", i, int'(bv_a[i]), int'(mv[i]));
                chk("Busy", i, int'(bs_a[i]), int'(busy_e));
                chk("EvalCount", i, ec_a[i], mec[i]);
                chk("TakenCount", i, tc_a[i], mtc[i]);
            end
            ack_s = BranchAck;
            clr_s = CntClr;
        end
    end

    // One stimulus cycle; requests push their expected decision per instance
    task automatic drive(bit con, bit [2:0] c, logic [31:0] b, bit ack, bit clr);
        ent_t e;
        @(posedge Clock);
        #1;
        CONin = con; IR = c; Bus = b; BranchAck = ack; CntClr = clr;
        if (con) begin
            for (int i = 0; i < 3; i++) begin
                e.due = ecount + 1 + pp(i);
                e.dec = ref_dec(c, b, dw(i));
                sbq[i].push_back(e);
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        drive(1'b1, 3'd4, 32'd1, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        CONin = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("busy_before_rst", i, int'(bs_a[i]), pp(i));
        #1;
        Clear_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_BranchOut", i, int'(bo_a[i]), 0);
            chk("rst_BranchValid", i, int'(bv_a[i]), 0);
            chk("rst_Busy", i, int'(bs_a[i]), 0);
            chk("rst_EvalCount", i, ec_a[i], 0);
            chk("rst_TakenCount", i, tc_a[i], 0);
            sbq[i].delete();
        end
        @(posedge Clock);
        #1;
        Clear_n = 1'b1;
        idle(4);
    endtask

    logic [31:0] pats [4];

    initial begin
        Clear_n = 1'b0; CONin = 1'b0; IR = 3'd0; Bus = 32'd0;
        BranchAck = 1'b0; CntClr = 1'b0;
        pats[0] = 32'h0000_0000;
        pats[1] = 32'h0000_0005;
        pats[2] = 32'h8000_0000;
        pats[3] = 32'h0000_0080;
        repeat (3) @(posedge Clock);
        #1;
        Clear_n = 1'b1;

        // Legacy pulse: brzr on zero, then CONin drops
        drive(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        idle(3);

        // Every code against each operand pattern, ack held high
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 8; c++)
                drive(1'b1, 3'(c), pats[p], 1'b1, 1'b0);
        idle(3);

        // Sticky hold, ack release, result coincident with ack
        drive(1'b1, 3'd1, 32'd7, 1'b0, 1'b0);
        idle(5);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 3'd1, 32'd7, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 3'd5, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        idle(2);
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);

        // Back-to-back requests through the pipeline
        drive(1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 32'd0, 1'b0, 1'b0);
        idle(4);

        // Counter saturation and clear-vs-increment priority
        drive(1'b0, 3'd0, 32'd0, 1'b1, 1'b1);
        repeat (5) drive(1'b1, 3'd4, 32'd0, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 3'd4, 32'd0, 1'b1, 1'b1);
        idle(3);

        // Randomised traffic
        repeat (600) begin
            logic [31:0] b;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'h0000_0080;
                2: b = 32'h8000_0000;
                3: b = 32'h0000_8000;
                default: b = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), b,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
        end
        idle(3);

        // Asynchronous reset while the input stage is occupied
        mid_reset();
        drive(1'b1, 3'd2, 32'd3, 1'b0, 1'b0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
